// File: rtl/pht_access_scheduler_pkg.sv
// Shared branch-predictor types: 2-bit counter encoding, scheduler FSM
// states and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_state_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    UPD_WR = 2'd2
  } pht_sched_state_t;

  // Move one step towards the resolved direction and saturate at both ends.
  function automatic ctr_state_t sat_next(input ctr_state_t cur, input logic taken);
    ctr_state_t nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pht_access_scheduler_if.sv
// Lookup, prediction and update channels of the PHT access scheduler.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid and its payload stay stable until that edge, and
// ready never depends combinationally on valid.
interface pht_access_scheduler_if #(
  parameter int IDX_W = 6
);
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic [1:0]       pred_state;
  logic             update_valid;
  logic [IDX_W-1:0] update_idx;
  logic             update_taken;
  logic             update_ready;
  logic             init_done;

  modport master (
    output lookup_valid, lookup_idx, update_valid, update_idx, update_taken,
    input  lookup_ready, pred_valid, pred_taken, pred_state, update_ready, init_done
  );

  modport slave (
    input  lookup_valid, lookup_idx, update_valid, update_idx, update_taken,
    output lookup_ready, pred_valid, pred_taken, pred_state, update_ready, init_done
  );
endinterface

// File: rtl/pht_access_scheduler_update_fifo.sv
// Synchronous FIFO holding pending {idx, taken} training requests.
// The caller only pushes when not full and only pops when not empty.
module pht_update_fifo #(
  parameter int IDX_W = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [IDX_W-1:0]         push_idx,
  input  logic                     push_taken,
  input  logic                     pop,
  output logic [IDX_W-1:0]         head_idx,
  output logic                     head_taken,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign {head_idx, head_taken} = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; simultaneous push/pop keeps occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {push_idx, push_taken};
  end

endmodule

// File: rtl/pht_access_scheduler.sv
// PHT of 2-bit counters behind a single access port shared by fetch lookups
// and queued retire-time read-modify-write updates.
module pht_access_scheduler
  import bp_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int UPD_DEPTH  = 4,
  parameter int INIT_STATE = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  pht_access_scheduler_if.slave       bus,
  output pht_sched_state_t            dbg_state,
  output logic [$clog2(UPD_DEPTH):0]  dbg_q_count
);
  localparam int         ENTRIES  = 1 << IDX_W;
  localparam ctr_state_t INIT_CTR = ctr_state_t'(INIT_STATE[1:0]);

  pht_sched_state_t state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] rmw_idx_q, rmw_idx_d;
  logic             rmw_taken_q, rmw_taken_d;
  ctr_state_t       rmw_old_q, rmw_old_d;
  logic             pred_valid_q, pred_valid_d;
  ctr_state_t       pred_state_q, pred_state_d;
  ctr_state_t       pht_q [ENTRIES];

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  ctr_state_t       mem_wdata;
  logic             lookup_ready;

  // Update queue readiness uses registered occupancy only.
  assign bus.update_ready = (state_q != INIT) && !fifo_full;
  assign fifo_push        = bus.update_valid && bus.update_ready;
  assign bus.lookup_ready = lookup_ready;
  assign bus.init_done    = (state_q != INIT);
  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_state   = pred_state_q;
  assign bus.pred_taken   = pred_state_q[1];
  assign dbg_state        = state_q;

  pht_update_fifo #(.IDX_W(IDX_W), .DEPTH(UPD_DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (fifo_push),
    .push_idx   (bus.update_idx),
    .push_taken (bus.update_taken),
    .pop        (fifo_pop),
    .head_idx   (head_idx),
    .head_taken (head_taken),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (dbg_q_count)
  );

  // Port arbitration: full queue drains first, then lookups, then idle RMW.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    rmw_idx_d    = rmw_idx_q;
    rmw_taken_d  = rmw_taken_q;
    rmw_old_d    = rmw_old_q;
    pred_valid_d = 1'b0;
    pred_state_d = pred_state_q;
    fifo_pop     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = sweep_q;
    mem_wdata    = INIT_CTR;
    lookup_ready = 1'b0;
    case (state_q)
      INIT: begin
        mem_we  = 1'b1;
        sweep_d = sweep_q + IDX_W'(1);
        if (&sweep_q) state_d = RUN;
      end
      RUN: begin
        lookup_ready = !fifo_full;
        if (fifo_full || (!bus.lookup_valid && !fifo_empty)) begin
          fifo_pop    = 1'b1;
          rmw_idx_d   = head_idx;
          rmw_taken_d = head_taken;
          rmw_old_d   = pht_q[head_idx];
          state_d     = UPD_WR;
        end else if (bus.lookup_valid) begin
          pred_valid_d = 1'b1;
          pred_state_d = pht_q[bus.lookup_idx];
        end
      end
      UPD_WR: begin
        mem_we    = 1'b1;
        mem_waddr = rmw_idx_q;
        mem_wdata = sat_next(rmw_old_q, rmw_taken_q);
        state_d   = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  // Control and prediction registers; reset abandons any RMW in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      rmw_idx_q    <= '0;
      rmw_taken_q  <= 1'b0;
      rmw_old_q    <= SNT;
      pred_valid_q <= 1'b0;
      pred_state_q <= SNT;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      rmw_idx_q    <= rmw_idx_d;
      rmw_taken_q  <= rmw_taken_d;
      rmw_old_q    <= rmw_old_d;
      pred_valid_q <= pred_valid_d;
      pred_state_q <= pred_state_d;
    end
  end

  // Counter table; the init sweep defines every entry, so no reset.
  always_ff @(posedge clock) begin
    if (mem_we) pht_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_pht_access_scheduler.sv
// Directed bench for pht_access_scheduler with hand-computed expectations.
module tb_pht_access_scheduler;
  import bp_pkg::*;

  logic             clock;
  logic             reset_n;
  pht_sched_state_t dbg_state;
  logic [2:0]       dbg_q_count;
  int               checks   = 0;
  int               failures = 0;
  logic [1:0]       exp_q[$];
  logic [1:0]       got_state;
  logic             got_taken;

  pht_access_scheduler_if #(.IDX_W(6)) bus ();

  pht_access_scheduler #(.IDX_W(6), .UPD_DEPTH(4), .INIT_STATE(1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .dbg_state   (dbg_state),
    .dbg_q_count (dbg_q_count)
  );

  // Clock and global time limit.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver: one lookup, returns the registered prediction.
  task automatic do_lookup(input logic [5:0] idx, output logic [1:0] st, output logic tk);
    int n;
    @(negedge clock);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = idx;
    n = 0;
    while (!bus.lookup_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("lookup_ready_wait", n < 50, 1);
    @(posedge clock);
    #1;
    bus.lookup_valid = 1'b0;
    check("pred_valid_pulse", bus.pred_valid, 1);
    st = bus.pred_state;
    tk = bus.pred_taken;
  endtask

  // Driver: one update, returns 1 ns after the accepting edge.
  task automatic push_update(input logic [5:0] idx, input logic taken);
    int n;
    @(negedge clock);
    bus.update_valid = 1'b1;
    bus.update_idx   = idx;
    bus.update_taken = taken;
    n = 0;
    while (!bus.update_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("update_ready_wait", n < 50, 1);
    @(posedge clock);
    #1;
    bus.update_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((dbg_q_count != 3'd0 || dbg_state != RUN) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_wait", n < 100, 1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!bus.init_done && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, n, 64);
  endtask

  task automatic lookup_expect(input string tag, input logic [5:0] idx,
                               input logic [1:0] exp_st);
    do_lookup(idx, got_state, got_taken);
    check(tag, got_state, exp_st);
    check({tag, "_taken"}, got_taken, exp_st[1]);
  endtask

  // Scoreboard: pop expected counters in order against lookups of idx_list.
  task automatic score_lookups(input string tag, input logic [5:0] idx_list[$]);
    logic [1:0] exp_v;
    foreach (idx_list[i]) begin
      do_lookup(idx_list[i], got_state, got_taken);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        check(tag, got_state, exp_v);
      end
    end
  endtask

  initial begin
    logic [5:0] idx_list[$];
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = '0;
    bus.update_valid = 1'b0;
    bus.update_idx   = '0;
    bus.update_taken = 1'b0;
    reset_n = 1'b0;
    #23;
    // Reset values.
    check("rst_pred_valid", bus.pred_valid, 0);
    check("rst_pred_taken", bus.pred_taken, 0);
    check("rst_pred_state", bus.pred_state, 0);
    check("rst_lookup_ready", bus.lookup_ready, 0);
    check("rst_update_ready", bus.update_ready, 0);
    check("rst_init_done", bus.init_done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("init_cycles");

    // First lookup after init, then pred_valid drops and state holds.
    lookup_expect("lookup17", 6'd17, 2'd1);
    @(posedge clock);
    #1;
    check("pred_valid_one_cycle", bus.pred_valid, 0);
    check("pred_state_hold", bus.pred_state, 1);

    // Train idx 5 up to ST, then back down to WNT.
    for (int i = 0; i < 3; i++) push_update(6'd5, 1'b1);
    wait_drained();
    lookup_expect("idx5_after_3t", 6'd5, 2'd3);
    for (int i = 0; i < 2; i++) push_update(6'd5, 1'b0);
    wait_drained();
    lookup_expect("idx5_after_2nt", 6'd5, 2'd1);

    // Saturation at both ends on idx 9.
    for (int i = 0; i < 5; i++) push_update(6'd9, 1'b0);
    wait_drained();
    lookup_expect("idx9_sat_low", 6'd9, 2'd0);
    for (int i = 0; i < 5; i++) push_update(6'd9, 1'b1);
    wait_drained();
    lookup_expect("idx9_sat_high", 6'd9, 2'd3);

    // Lookup in the RUN cycle right after UPD_WR sees the written value.
    push_update(6'd9, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("rmw_write_phase", dbg_state, UPD_WR);
    lookup_expect("idx9_after_wr", 6'd9, 2'd2);

    // Lookups every cycle: queue fills, forced drain blocks lookups.
    @(negedge clock);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 6'd0;
    push_update(6'd20, 1'b1);
    push_update(6'd21, 1'b1);
    push_update(6'd22, 1'b0);
    push_update(6'd23, 1'b1);
    check("full_occupancy", dbg_q_count, 4);
    check("full_update_ready", bus.update_ready, 0);
    check("full_lookup_ready", bus.lookup_ready, 0);
    @(posedge clock);
    #1;
    check("forced_wr_state", dbg_state, UPD_WR);
    check("forced_wr_occupancy", dbg_q_count, 3);
    check("forced_wr_lookup_ready", bus.lookup_ready, 0);
    check("forced_wr_update_ready", bus.update_ready, 1);
    bus.lookup_valid = 1'b1;
    push_update(6'd20, 1'b1);
    check("refill_occupancy", dbg_q_count, 4);
    check("refill_lookup_ready", bus.lookup_ready, 0);
    bus.lookup_valid = 1'b0;
    wait_drained();
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    idx_list = '{6'd20, 6'd21, 6'd22, 6'd23};
    score_lookups("burst_apply", idx_list);

    // Reset pulse during UPD_WR with three updates still queued.
    @(negedge clock);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 6'd0;
    for (int i = 1; i <= 4; i++) push_update(6'(i), 1'b1);
    @(posedge clock);
    #1;
    check("pre_reset_state", dbg_state, UPD_WR);
    check("pre_reset_occupancy", dbg_q_count, 3);
    reset_n = 1'b0;
    bus.lookup_valid = 1'b0;
    #1;
    check("mid_rst_occupancy", dbg_q_count, 0);
    check("mid_rst_pred_valid", bus.pred_valid, 0);
    check("mid_rst_init_done", bus.init_done, 0);
    check("mid_rst_update_ready", bus.update_ready, 0);
    check("mid_rst_state", dbg_state, INIT);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wait_init("reinit_cycles");
    idx_list.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(2'd1);
      idx_list.push_back(6'(i));
    end
    score_lookups("sweep_entry", idx_list);

    // Push and pop in the same cycle at occupancy 2; order must hold.
    @(negedge clock);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = 6'd0;
    push_update(6'd40, 1'b0);
    push_update(6'd40, 1'b0);
    check("pre_pushpop_occupancy", dbg_q_count, 2);
    bus.lookup_valid = 1'b0;
    push_update(6'd40, 1'b1);
    check("pushpop_occupancy", dbg_q_count, 2);
    check("pushpop_state", dbg_state, UPD_WR);
    wait_drained();
    lookup_expect("order_idx40", 6'd40, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
